// File: rtl/fft_seq_if.sv
// rtl/fft_seq_if.sv - handshake bundle between the FFT sequencer and its datapath/source/sink
// Optional perf counters appear when FFT_SEQ_PERF_EN is defined.
interface fft_seq_if #(
    parameter int LOGN = 4
);
    logic            start;
    logic            in_valid;
    logic            ld_we;
    logic [LOGN-1:0] ld_addr;
    logic            bf_valid;
    logic            bf_ready;
    logic [LOGN-1:0] addr_a;
    logic [LOGN-1:0] addr_b;
    logic [LOGN-2:0] tw_idx;
    logic [LOGN-1:0] stage;
    logic            wb_valid;
    logic            rd_valid;
    logic            rd_ready;
    logic [LOGN-1:0] rd_addr;
    logic            busy;
    logic            done;
    logic            err;
`ifdef FFT_SEQ_PERF_EN
    logic [31:0]     cyc_cnt;
    logic [31:0]     stall_cnt;
`endif

    modport master (
        input  start, in_valid, bf_ready, wb_valid, rd_ready,
        output ld_we, ld_addr, bf_valid, addr_a, addr_b, tw_idx, stage,
               rd_valid, rd_addr, busy, done, err
`ifdef FFT_SEQ_PERF_EN
        , output cyc_cnt, stall_cnt
`endif
    );

    modport slave (
        output start, in_valid, bf_ready, wb_valid, rd_ready,
        input  ld_we, ld_addr, bf_valid, addr_a, addr_b, tw_idx, stage,
               rd_valid, rd_addr, busy, done, err
`ifdef FFT_SEQ_PERF_EN
        , input cyc_cnt, stall_cnt
`endif
    );
endinterface

// File: rtl/fft_seq_ctrl.sv
// rtl/fft_seq_ctrl.sv - in-place radix-2 DIT FFT sequencer (load, butterfly issue, output read)
// Define FFT_SEQ_PERF_EN to add the cyc_cnt/stall_cnt performance counters.
module fft_seq_ctrl #(
    parameter int N         = 16,
    parameter int LOGN      = $clog2(N),
    parameter int MAX_OUTST = 4
) (
    input  logic      clk,
    input  logic      rst,
    fft_seq_if.master bus
);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam logic [LOGN-1:0] LAST       = LOGN'(N - 1);
    localparam logic [LOGN-1:0] HALF_LAST  = LOGN'(N / 2 - 1);
    localparam logic [LOGN-1:0] LAST_STAGE = LOGN'(LOGN - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_DRAIN, S_OUT} state_t;

    state_t          state_q, state_d;
    logic [LOGN-1:0] cnt_q, cnt_d;
    logic [LOGN-1:0] j_q, j_d;
    logic [LOGN-1:0] stage_q, stage_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [LOGN-1:0] half, pos, base, a_w, tw_w, rev;
    logic            calc, bf_valid_w, bf_xfer;

    assign calc       = (state_q == S_CALC);
    assign bf_valid_w = calc && (outst_q < OW'(MAX_OUTST));
    assign bf_xfer    = bf_valid_w && bus.bf_ready;

    // Butterfly j of stage s: groups of 2*half, offset pos within the group.
    always_comb begin
        half = LOGN'(1) << stage_q;
        pos  = j_q & (half - LOGN'(1));
        base = (j_q >> stage_q) << (stage_q + LOGN'(1));
        a_w  = base + pos;
        tw_w = pos << (LAST_STAGE - stage_q);
        rev  = '0;
        for (int i = 0; i < LOGN; i++) begin
            rev[i] = cnt_q[LOGN-1-i];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        stage_d = stage_q;
        outst_d = outst_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case ({bf_xfer, bus.wb_valid})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01: begin
                if (outst_q == '0) err_d = 1'b1;
                else               outst_d = outst_q - OW'(1);
            end
            default: outst_d = outst_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    j_d     = '0;
                    stage_d = '0;
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    if (cnt_q == LAST) begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        j_d     = '0;
                        stage_d = '0;
                    end else begin
                        cnt_d = cnt_q + LOGN'(1);
                    end
                end
            end
            S_CALC: begin
                if (bf_xfer) begin
                    if (j_q == HALF_LAST) begin
                        state_d = S_DRAIN;
                        j_d     = '0;
                    end else begin
                        j_d = j_q + LOGN'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Use the next outstanding count so the final write-back releases the barrier at once.
                if (outst_d == '0) begin
                    if (stage_q < LAST_STAGE) begin
                        stage_d = stage_q + LOGN'(1);
                        state_d = S_CALC;
                    end else begin
                        state_d = S_OUT;
                        cnt_d   = '0;
                    end
                end
            end
            S_OUT: begin
                if (bus.rd_ready) begin
                    if (cnt_q == LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + LOGN'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE) || done_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            j_q     <= '0;
            stage_q <= '0;
            outst_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            stage_q <= stage_d;
            outst_q <= outst_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.ld_we    = (state_q == S_LOAD) && bus.in_valid;
    assign bus.ld_addr  = (state_q == S_LOAD) ? rev : '0;
    assign bus.bf_valid = bf_valid_w;
    assign bus.addr_a   = calc ? a_w : '0;
    assign bus.addr_b   = calc ? (a_w + half) : '0;
    assign bus.tw_idx   = calc ? tw_w[LOGN-2:0] : '0;
    assign bus.stage    = stage_q;
    assign bus.rd_valid = (state_q == S_OUT);
    assign bus.rd_addr  = (state_q == S_OUT) ? cnt_q : '0;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

`ifdef FFT_SEQ_PERF_EN
    logic [31:0] cyc_q, cyc_d, stall_q, stall_d;

    always_comb begin
        cyc_d   = cyc_q;
        stall_d = stall_q;
        if (state_q == S_IDLE && bus.start) begin
            cyc_d   = '0;
            stall_d = '0;
        end else begin
            if ((state_q == S_CALC || state_q == S_DRAIN) && cyc_q != '1)
                cyc_d = cyc_q + 32'd1;
            if (bf_valid_w && !bus.bf_ready && stall_q != '1)
                stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            stall_q <= stall_d;
        end
    end

    assign bus.cyc_cnt   = cyc_q;
    assign bus.stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb/tb_fft_seq_ctrl.sv - directed self-checking bench for fft_seq_ctrl (N=16)
module tb_fft_seq_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic auto_wb;
    logic wb_manual;
    logic [1:0] wb_pipe;
    int n_checks = 0;
    int n_fail = 0;

    logic [3:0] la [256];
    logic [3:0] lb [256];
    logic [3:0] ls [256];
    logic [2:0] lt [256];
    int log_n = 0;

    fft_seq_if #(.LOGN(4)) ifc ();

    fft_seq_ctrl #(.N(16), .LOGN(4), .MAX_OUTST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    wire xfer = ifc.bf_valid & ifc.bf_ready;
    assign ifc.wb_valid = wb_pipe[1] | wb_manual;

    // Write-back model: each captured transfer returns wb_valid two cycles later.
    always @(posedge clk) begin
        if (!rst) wb_pipe <= 2'b00;
        else      wb_pipe <= {wb_pipe[0], xfer & auto_wb};
        if (rst === 1'b1 && xfer === 1'b1 && log_n < 256) begin
            la[log_n] <= ifc.addr_a;
            lb[log_n] <= ifc.addr_b;
            lt[log_n] <= ifc.tw_idx;
            ls[log_n] <= ifc.stage;
            log_n     <= log_n + 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ifc.start = 1'b0; ifc.in_valid = 1'b0; ifc.bf_ready = 1'b0; ifc.rd_ready = 1'b0;
        auto_wb = 1'b0; wb_manual = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
    endtask

    task automatic start_and_load();
        ifc.start = 1'b1; cyc(); ifc.start = 1'b0;
        ifc.in_valid = 1'b1;
        repeat (16) cyc();
        ifc.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", ifc.busy); end
        n_checks++; if (ifc.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", ifc.done); end
        n_checks++; if (ifc.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0b exp=0", ifc.err); end
        n_checks++;
        if ({ifc.bf_valid, ifc.rd_valid, ifc.ld_we, ifc.stage, ifc.addr_a, ifc.addr_b, ifc.tw_idx, ifc.rd_addr, ifc.ld_addr} !== '0) begin
            n_fail++; $display("FAIL reset_outputs bf_valid=%0b rd_valid=%0b ld_we=%0b stage=%0d addr_a=%0d exp all 0",
                               ifc.bf_valid, ifc.rd_valid, ifc.ld_we, ifc.stage, ifc.addr_a);
        end
    endtask

    task automatic test_load();
        logic [3:0] exp_rev [16];
        exp_rev = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                    4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};
        ifc.start = 1'b1; cyc(); ifc.start = 1'b0;
        #1;
        n_checks++; if (ifc.busy !== 1'b1) begin n_fail++; $display("FAIL load_busy got=%0b exp=1", ifc.busy); end
        for (int i = 0; i < 16; i++) begin
            ifc.in_valid = 1'b1;
            #1;
            n_checks++;
            if (ifc.ld_we !== 1'b1 || ifc.ld_addr !== exp_rev[i]) begin
                n_fail++; $display("FAIL load_addr[%0d] ld_we=%0b ld_addr=%0d exp ld_we=1 ld_addr=%0d", i, ifc.ld_we, ifc.ld_addr, exp_rev[i]);
            end
            cyc();
        end
        ifc.in_valid = 1'b0;
        #1;
        n_checks++; if (ifc.ld_we !== 1'b0) begin n_fail++; $display("FAIL load_end_we got=%0b exp=0", ifc.ld_we); end
    endtask

    task automatic test_addr_gen();
        int base, c, cnt_s, s, j, h, ea, eb, et;
        base = log_n;
        ifc.bf_ready = 1'b1; auto_wb = 1'b1;
        c = 0;
        while (ifc.rd_valid !== 1'b1 && c < 400) begin cyc(); c++; end
        n_checks++; if (c >= 400) begin n_fail++; $display("FAIL addr_timeout cycles=%0d exp<400", c); end
        n_checks++; if (log_n - base !== 32) begin n_fail++; $display("FAIL addr_total got=%0d exp=32", log_n - base); end
        for (int st = 0; st < 4; st++) begin
            cnt_s = 0;
            for (int k = base; k < log_n; k++) if (ls[k] == 4'(st)) cnt_s++;
            n_checks++; if (cnt_s !== 8) begin n_fail++; $display("FAIL addr_stage_count[%0d] got=%0d exp=8", st, cnt_s); end
        end
        n_checks++; if ({la[base], lb[base], lt[base]} !== {4'd0, 4'd1, 3'd0}) begin
            n_fail++; $display("FAIL addr_s0j0 got=(%0d,%0d,%0d) exp=(0,1,0)", la[base], lb[base], lt[base]); end
        n_checks++; if ({la[base+11], lb[base+11], lt[base+11]} !== {4'd5, 4'd7, 3'd4}) begin
            n_fail++; $display("FAIL addr_s1j3 got=(%0d,%0d,%0d) exp=(5,7,4)", la[base+11], lb[base+11], lt[base+11]); end
        n_checks++; if ({la[base+29], lb[base+29], lt[base+29]} !== {4'd5, 4'd13, 3'd5}) begin
            n_fail++; $display("FAIL addr_s3j5 got=(%0d,%0d,%0d) exp=(5,13,5)", la[base+29], lb[base+29], lt[base+29]); end
        for (int k = 0; k < 32; k++) begin
            s = k / 8; j = k % 8; h = 1 << s;
            ea = (j / h) * 2 * h + (j % h); eb = ea + h; et = (j % h) * (8 / h);
            n_checks++;
            if (la[base+k] !== 4'(ea) || lb[base+k] !== 4'(eb) || lt[base+k] !== 3'(et) || ls[base+k] !== 4'(s)) begin
                n_fail++; $display("FAIL addr_seq[%0d] got=(%0d,%0d,%0d,s%0d) exp=(%0d,%0d,%0d,s%0d)",
                                   k, la[base+k], lb[base+k], lt[base+k], ls[base+k], ea, eb, et, s);
            end
        end
        ifc.bf_ready = 1'b0; auto_wb = 1'b0;
    endtask

    task automatic test_output();
        int idx, p, c;
        idx = 0; p = 0; c = 0;
        while (idx < 16 && c < 100) begin
            ifc.rd_ready = (p % 3 != 1);
            p++; c++;
            #1;
            n_checks++;
            if (ifc.rd_valid !== 1'b1 || ifc.rd_addr !== 4'(idx)) begin
                n_fail++; $display("FAIL out_addr[%0d] rd_valid=%0b rd_addr=%0d exp rd_valid=1 rd_addr=%0d", idx, ifc.rd_valid, ifc.rd_addr, idx);
            end
            if (ifc.rd_ready) idx++;
            cyc();
        end
        ifc.rd_ready = 1'b0;
        #1;
        n_checks++; if (ifc.done !== 1'b1 || ifc.busy !== 1'b1 || ifc.rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL out_done done=%0b busy=%0b rd_valid=%0b exp 1,1,0", ifc.done, ifc.busy, ifc.rd_valid); end
        cyc(); #1;
        n_checks++; if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin
            n_fail++; $display("FAIL out_after done=%0b busy=%0b exp 0,0", ifc.done, ifc.busy); end
    endtask

    task automatic test_backpressure();
        int base, c;
        start_and_load();
        base = log_n;
        ifc.bf_ready = 1'b1; auto_wb = 1'b1;
        c = 0;
        while (log_n - base < 3 && c < 50) begin cyc(); c++; end
        ifc.bf_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if ({ifc.bf_valid, ifc.addr_a, ifc.addr_b, ifc.tw_idx} !== {1'b1, 4'd6, 4'd7, 3'd0}) begin
                n_fail++; $display("FAIL bp_hold[%0d] got v=%0b (%0d,%0d,%0d) exp v=1 (6,7,0)", i, ifc.bf_valid, ifc.addr_a, ifc.addr_b, ifc.tw_idx);
            end
            cyc();
        end
        auto_wb = 1'b0; ifc.bf_ready = 1'b1;
        repeat (8) cyc();
        #1;
        n_checks++; if (log_n - base !== 7) begin n_fail++; $display("FAIL outst_limit_xfers got=%0d exp=7", log_n - base); end
        n_checks++; if (ifc.bf_valid !== 1'b0) begin n_fail++; $display("FAIL outst_limit_valid got=%0b exp=0", ifc.bf_valid); end
        wb_manual = 1'b1; cyc(); wb_manual = 1'b0;
        #1;
        n_checks++; if (ifc.bf_valid !== 1'b1) begin n_fail++; $display("FAIL outst_resume got=%0b exp=1", ifc.bf_valid); end
        do_reset();
    endtask

    task automatic test_stage_barrier();
        int base, c;
        start_and_load();
        base = log_n;
        ifc.bf_ready = 1'b1; auto_wb = 1'b1;
        c = 0;
        while (log_n - base < 7 && c < 50) begin cyc(); c++; end
        auto_wb = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(); #1;
            n_checks++;
            if (ifc.stage !== 4'd0 || ifc.bf_valid !== 1'b0) begin
                n_fail++; $display("FAIL barrier_wait[%0d] stage=%0d bf_valid=%0b exp 0,0", i, ifc.stage, ifc.bf_valid);
            end
        end
        wb_manual = 1'b1; #1;
        n_checks++; if (ifc.stage !== 4'd0) begin n_fail++; $display("FAIL barrier_last_wb stage=%0d exp=0", ifc.stage); end
        cyc();
        wb_manual = 1'b0; auto_wb = 1'b1;
        #1;
        n_checks++;
        if ({ifc.bf_valid, ifc.stage, ifc.addr_a, ifc.addr_b, ifc.tw_idx} !== {1'b1, 4'd1, 4'd0, 4'd2, 3'd0}) begin
            n_fail++; $display("FAIL barrier_release got v=%0b s=%0d (%0d,%0d,%0d) exp v=1 s=1 (0,2,0)",
                               ifc.bf_valid, ifc.stage, ifc.addr_a, ifc.addr_b, ifc.tw_idx);
        end
    endtask

    task automatic test_reset_err();
        int c;
        c = 0;
        while (ifc.stage !== 4'd2 && c < 100) begin cyc(); c++; end
        n_checks++; if (ifc.stage !== 4'd2) begin n_fail++; $display("FAIL rst_reach_stage2 stage=%0d exp=2", ifc.stage); end
        cyc(); cyc();
        auto_wb = 1'b0;
        rst = 1'b0; cyc(); rst = 1'b1;
        ifc.bf_ready = 1'b0;
        #1;
        n_checks++;
        if ({ifc.busy, ifc.done, ifc.err, ifc.bf_valid, ifc.rd_valid, ifc.stage, ifc.addr_a, ifc.addr_b} !== '0) begin
            n_fail++; $display("FAIL rst_mid busy=%0b done=%0b err=%0b bf_valid=%0b stage=%0d addr_a=%0d exp all 0",
                               ifc.busy, ifc.done, ifc.err, ifc.bf_valid, ifc.stage, ifc.addr_a);
        end
        wb_manual = 1'b1; cyc(); wb_manual = 1'b0;
        #1;
        n_checks++; if (ifc.err !== 1'b1) begin n_fail++; $display("FAIL err_set got=%0b exp=1", ifc.err); end
        repeat (3) cyc();
        ifc.start = 1'b1; cyc(); ifc.start = 1'b0;
        #1;
        n_checks++; if (ifc.err !== 1'b1 || ifc.busy !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky err=%0b busy=%0b exp 1,1", ifc.err, ifc.busy); end
        do_reset();
        #1;
        n_checks++; if (ifc.err !== 1'b0) begin n_fail++; $display("FAIL err_clear got=%0b exp=0", ifc.err); end
    endtask

    initial begin
        rst = 1'b0;
        ifc.start = 1'b0; ifc.in_valid = 1'b0; ifc.bf_ready = 1'b0; ifc.rd_ready = 1'b0;
        auto_wb = 1'b0; wb_manual = 1'b0;
        @(negedge clk);
        test_reset();
        test_load();
        test_addr_gen();
        test_output();
        test_backpressure();
        test_stage_barrier();
        test_reset_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
